// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, multiply/divide FSM encoding and the default operand width.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FINISH
  } state_e;

  // Which result set FINISH has to commit.
  typedef enum logic [1:0] {
    OPK_MUL,
    OPK_DIV,
    OPK_DIV0
  } op_kind_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shared shift-add multiply / restoring divide datapath: accumulator, adder/subtractor,
// shifters and iteration counter. One iteration per cycle while step is high.
module muldiv_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               load_div,
  input  logic               step,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               last_iter,
  output logic [2*WIDTH-1:0] mul_result,
  output logic [WIDTH-1:0]   div_quo,
  output logic [WIDTH-1:0]   div_rem
);

  localparam int CW = $clog2(WIDTH + 1);

  // Upper WIDTH+1 bits hold the partial product (with carry) or the remainder;
  // the lower WIDTH bits hold the multiplier being consumed or the quotient being built.
  logic [2*WIDTH:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH:0]   upper_sum;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH:0] shifted;

  // NOTE: every always_comb output is given its hold value first so no path infers a latch.
  always_comb begin
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    div_d     = div_q;
    count_d   = count_q;
    upper_sum = acc_q[2*WIDTH:WIDTH] + {1'b0, opnd_q};
    shifted   = {acc_q[2*WIDTH-1:0], 1'b0};
    trial     = shifted[2*WIDTH:WIDTH] - {1'b0, opnd_q};
    if (load) begin
      div_d   = load_div;
      count_d = CW'(WIDTH);
      opnd_d  = load_div ? op_b : op_a;
      acc_d   = {{(WIDTH+1){1'b0}}, (load_div ? op_a : op_b)};
    end else if (step) begin
      count_d = count_q - CW'(1);
      if (div_q) begin
        // A borrow out of the trial subtract means the divisor did not fit: restore.
        acc_d = trial[WIDTH] ? shifted : {trial, shifted[WIDTH-1:1], 1'b1};
      end else begin
        acc_d = acc_q[0] ? {1'b0, upper_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH:1]};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      count_q <= count_d;
    end
  end

  assign last_iter  = (count_q == CW'(1));
  assign mul_result = acc_q[2*WIDTH-1:0];
  assign div_quo    = acc_q[WIDTH-1:0];
  assign div_rem    = acc_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_muldiv_unit.sv
// Iterative multiply/divide responder: FSM, start/done handshake, result and flag registers.
// Define MULDIV_SIGNED_EN for two's-complement operands; default build is unsigned.
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_mul,
  input  logic               start_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               busy,
  output logic               mul_done,
  output logic               div_done
);

  state_e             state_q, state_d;
  op_kind_e           kind_q, kind_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   quotient_q, quotient_d;
  logic [WIDTH-1:0]   remainder_q, remainder_d;
  logic               dbz_q, dbz_d;
  logic               mul_done_q, mul_done_d;
  logic               div_done_q, div_done_d;

  logic               accept, dp_load, dp_load_div, dp_step, dp_last;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] dp_product, mul_res;
  logic [WIDTH-1:0]   dp_quo, dp_rem, quo_res, rem_res;

  assign accept = (state_q == ST_IDLE) && (start_mul || start_div);

`ifdef MULDIV_SIGNED_EN
  logic sign_a_q, sign_a_d, sign_b_q, sign_b_d;

  always_comb begin
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    if (accept) begin
      sign_a_d = a[WIDTH-1];
      sign_b_d = b[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
    end
  end

  // Magnitude of the most-negative value wraps to itself, which is its correct unsigned magnitude.
  assign a_mag   = a[WIDTH-1] ? -a : a;
  assign b_mag   = b[WIDTH-1] ? -b : b;
  assign mul_res = (sign_a_q ^ sign_b_q) ? -dp_product : dp_product;
  assign quo_res = (sign_a_q ^ sign_b_q) ? -dp_quo : dp_quo;
  assign rem_res = sign_a_q ? -dp_rem : dp_rem;
`else
  assign a_mag   = a;
  assign b_mag   = b;
  assign mul_res = dp_product;
  assign quo_res = dp_quo;
  assign rem_res = dp_rem;
`endif

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (dp_load),
    .load_div   (dp_load_div),
    .step       (dp_step),
    .op_a       (a_mag),
    .op_b       (b_mag),
    .last_iter  (dp_last),
    .mul_result (dp_product),
    .div_quo    (dp_quo),
    .div_rem    (dp_rem)
  );

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    a_d         = a_q;
    product_d   = product_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    mul_done_d  = 1'b0;
    div_done_d  = 1'b0;
    dp_load     = 1'b0;
    dp_load_div = 1'b0;
    dp_step     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Multiply wins when both requests arrive together.
        if (start_mul) begin
          dp_load = 1'b1;
          kind_d  = OPK_MUL;
          a_d     = a;
          state_d = ST_MUL;
        end else if (start_div) begin
          a_d = a;
          if (b == '0) begin
            kind_d  = OPK_DIV0;
            state_d = ST_FINISH;
          end else begin
            dp_load     = 1'b1;
            dp_load_div = 1'b1;
            kind_d      = OPK_DIV;
            state_d     = ST_DIV;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        dp_step = 1'b1;
        if (dp_last) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        unique case (kind_q)
          OPK_MUL: begin
            product_d  = mul_res;
            mul_done_d = 1'b1;
          end
          OPK_DIV: begin
            quotient_d  = quo_res;
            remainder_d = rem_res;
            dbz_d       = 1'b0;
            div_done_d  = 1'b1;
          end
          default: begin
            quotient_d  = '1;
            remainder_d = a_q;
            dbz_d       = 1'b1;
            div_done_d  = 1'b1;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: every flop, result registers included, is asynchronously reset so an abort leaves no stale output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      kind_q      <= OPK_MUL;
      a_q         <= '0;
      product_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      mul_done_q  <= 1'b0;
      div_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      a_q         <= a_d;
      product_q   <= product_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      mul_done_q  <= mul_done_d;
      div_done_q  <= div_done_d;
    end
  end

  assign product     = product_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q != ST_IDLE);
  assign mul_done    = mul_done_q;
  assign div_done    = div_done_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit: vector table plus hand-written handshake/reset sequences.
module tb_alu_muldiv_unit;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start_mul = 1'b0;
  logic           start_div = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic [2*W-1:0] product;
  logic [W-1:0]   quotient, remainder;
  logic           div_by_zero, busy, mul_done, div_done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_mul;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] e_prod;
    logic [7:0]  e_quo;
    logic [7:0]  e_rem;
    logic        e_dbz;
    int          e_lat;
  } vec_t;

  vec_t vecs[$];

  alu_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start_mul   (start_mul),
    .start_div   (start_div),
    .a           (a),
    .b           (b),
    .product     (product),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .mul_done    (mul_done),
    .div_done    (div_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulses a start at the next falling edge, scrambles the operands after the sampling edge,
  // optionally fires start_div on edge inj, then watches 12 edges for done pulses and busy.
  task automatic run_op(input logic m, input logic d, input logic [7:0] a_v, input logic [7:0] b_v,
                        input int inj, output int lat, output int n_mul, output int n_div,
                        output int busy_cnt);
    @(negedge clk);
    start_mul = m;
    start_div = d;
    a = a_v;
    b = b_v;
    @(posedge clk);
    #1;
    start_mul = 1'b0;
    start_div = 1'b0;
    a = 8'hA5;
    b = 8'h5A;
    lat = -1;
    n_mul = 0;
    n_div = 0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= 12; i++) begin
      if (i == inj) begin
        @(negedge clk);
        start_div = 1'b1;
        b = 8'h00;
      end
      @(posedge clk);
      #1;
      start_div = 1'b0;
      if (mul_done) n_mul++;
      if (div_done) n_div++;
      if ((mul_done || div_done) && lat < 0) lat = i;
      if (busy) busy_cnt++;
    end
  endtask

  initial begin
    int lat, n_mul, n_div, busy_cnt;

`ifdef MULDIV_SIGNED_EN
    vecs.push_back('{1'b1, 8'hFD, 8'h05, 16'hFFF1, 8'h00, 8'h00, 1'b0, 9});
    vecs.push_back('{1'b0, 8'hF9, 8'h02, 16'hFFF1, 8'hFD, 8'hFF, 1'b0, 9});
    vecs.push_back('{1'b0, 8'h80, 8'hFF, 16'hFFF1, 8'h80, 8'h00, 1'b0, 9});
    vecs.push_back('{1'b0, 8'h9C, 8'h00, 16'hFFF1, 8'hFF, 8'h9C, 1'b1, 1});
    vecs.push_back('{1'b1, 8'hF9, 8'hFE, 16'h000E, 8'hFF, 8'h9C, 1'b1, 9});
    vecs.push_back('{1'b0, 8'h07, 8'hFE, 16'h000E, 8'hFD, 8'h01, 1'b0, 9});
`else
    vecs.push_back('{1'b1, 8'd13,  8'd11,  16'h008F, 8'h00, 8'h00, 1'b0, 9});
    vecs.push_back('{1'b1, 8'd255, 8'd255, 16'hFE01, 8'h00, 8'h00, 1'b0, 9});
    vecs.push_back('{1'b0, 8'd200, 8'd7,   16'hFE01, 8'd28, 8'd4,  1'b0, 9});
    vecs.push_back('{1'b0, 8'd100, 8'd0,   16'hFE01, 8'hFF, 8'd100, 1'b1, 1});
    vecs.push_back('{1'b0, 8'd9,   8'd3,   16'hFE01, 8'd3,  8'd0,  1'b0, 9});
    vecs.push_back('{1'b1, 8'd0,   8'd200, 16'h0000, 8'd3,  8'd0,  1'b0, 9});
    vecs.push_back('{1'b0, 8'd5,   8'd9,   16'h0000, 8'd0,  8'd5,  1'b0, 9});
    vecs.push_back('{1'b0, 8'd255, 8'd1,   16'h0000, 8'hFF, 8'd0,  1'b0, 9});
    vecs.push_back('{1'b1, 8'd128, 8'd2,   16'h0100, 8'hFF, 8'd0,  1'b0, 9});
    vecs.push_back('{1'b0, 8'd255, 8'd16,  16'h0100, 8'd15, 8'd15, 1'b0, 9});
`endif

    #12;
    check("reset_outputs", {product, quotient, remainder, div_by_zero, busy, mul_done, div_done}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].is_mul, !vecs[i].is_mul, vecs[i].a, vecs[i].b, 0, lat, n_mul, n_div, busy_cnt);
      check($sformatf("v%0d_latency", i), lat, vecs[i].e_lat);
      check($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].e_lat);
      check($sformatf("v%0d_mul_done_count", i), n_mul, vecs[i].is_mul ? 1 : 0);
      check($sformatf("v%0d_div_done_count", i), n_div, vecs[i].is_mul ? 0 : 1);
      check($sformatf("v%0d_product", i), product, vecs[i].e_prod);
      check($sformatf("v%0d_quotient", i), quotient, vecs[i].e_quo);
      check($sformatf("v%0d_remainder", i), remainder, vecs[i].e_rem);
      check($sformatf("v%0d_div_by_zero", i), div_by_zero, vecs[i].e_dbz);
    end

    // start_div during a running multiply is dropped, not queued.
    run_op(1'b1, 1'b0, 8'd6, 8'd7, 3, lat, n_mul, n_div, busy_cnt);
    check("busy_ignore_mul_done", n_mul, 1);
    check("busy_ignore_div_done", n_div, 0);
    check("busy_ignore_product", product, 16'd42);

    // Simultaneous requests: multiply only.
    run_op(1'b1, 1'b1, 8'd3, 8'd4, 0, lat, n_mul, n_div, busy_cnt);
    check("both_mul_done", n_mul, 1);
    check("both_div_done", n_div, 0);
    check("both_product", product, 16'd12);

    // Reset in the middle of a divide aborts it immediately.
    @(negedge clk);
    start_div = 1'b1;
    a = 8'd100;
    b = 8'd7;
    @(posedge clk);
    #1;
    start_div = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("abort_busy_before", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort_outputs_zero", {product, quotient, remainder, div_by_zero, busy, mul_done, div_done}, 0);
    n_div = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (div_done || mul_done) n_div++;
      if (i == 2) reset_n = 1'b1;
    end
    check("abort_no_done", n_div, 0);

    run_op(1'b0, 1'b1, 8'd9, 8'd3, 0, lat, n_mul, n_div, busy_cnt);
    check("post_reset_latency", lat, 9);
    check("post_reset_quotient", quotient, 8'd3);
    check("post_reset_remainder", remainder, 8'd0);
    check("post_reset_product", product, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
